i2c_slave_regs: RTL
===================

# i2c_slave_regs

Bus-side target (responder) for the single-master I2C link driven by the XDCFEB I2C master engine. It decodes START/STOP, matches a 7-bit device address, and serves a 16 x 8-bit register file: master writes update registers, master reads return them MSB first. It runs on CLK40 and oversamples SCL/SDA; it is used both as an on-board target and as the loop-back partner for master verification.

## Interface
Parameters:
- DEV_ADDR, 7'h51, 7-bit target address (8'hA2 write / 8'hA3 read on the wire).

Ports:
- CLK40  in  1  system clock, 40 MHz; all logic on rising edge.
- RST  in  1  reset; synchronous, active-high.
- SCL_IN  in  1  raw SCL from pad, asynchronous.
- SDA_IN  in  1  raw SDA from pad, asynchronous.
- SDA_OE  out  1  1 = pull SDA low; 0 = release (pad tristates).
- LCL_WE  in  1  local register write strobe.
- LCL_ADDR  in  4  local register address for write and read.
- LCL_WDATA  in  8  local write data.
- LCL_RDATA  out  8  registers[LCL_ADDR], registered, 1-cycle latency.
- WR_STB  out  1  one-cycle pulse when an I2C data byte is committed.
- WR_ADDR  out  4  register index of that byte; valid with WR_STB.
- WR_DATA  out  8  byte value; valid with WR_STB.
- BUSY  out  1  high from matched address ACK until STOP or returning to IDLE.

## Operation
- Input conditioning: two-flop synchronizer per line plus one history flop; edges detected from stage 2 vs history.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both override every state.
- States: IDLE, DEVADR, DEVACK, PTR, PTRACK, WDATA, WDACK, RDATA, MACK, IGNORE.
- IDLE -> DEVADR on START. Any state -> DEVADR on START (repeated start); pointer retained.
- Any state -> IDLE on STOP; SDA_OE released same cycle.
- DEVADR: shift 8 bits on SCL rising. Match of bits[7:1] -> DEVACK; mismatch -> IGNORE (no ACK, wait START/STOP).
- DEVACK: drive SDA_OE=1 for the ACK bit. Then R/W=0 -> PTR; R/W=1 -> load shift reg from regs[ptr] -> RDATA.
- PTR: 8 bits; ptr <= byte[3:0] (bits[7:4] ignored); ACK in PTRACK -> WDATA.
- WDATA: 8 bits; on 8th rising edge regs[ptr] <= byte, WR_STB/WR_ADDR/WR_DATA issued, ptr increments; ACK in WDACK -> WDATA.
- RDATA: SDA_OE = ~shift[7], changing on SCL falling edge; 8 bits then MACK (SDA released).
- MACK: sample on SCL rising. 0 (ACK) -> ptr++, reload regs[ptr], RDATA. 1 (NACK) -> IGNORE.
- Pointer: 4 bits, wraps 15 -> 0.
- Collision: I2C commit and LCL_WE same cycle, same address -> I2C value wins; different addresses -> both written.
- RST: all registers 0x00, ptr 0, state IDLE.

## Timing
- Reset values: SDA_OE 0, LCL_RDATA 0x00, WR_STB 0, WR_ADDR 0, WR_DATA 0x00, BUSY 0.
- Edge detect latency: 3 CLK40 cycles from pad edge (2 sync + compare).
- SDA_OE changes only in the cycle SCL falling edge is detected (never while SCL high), except release on STOP/RST.
- ACK drive: asserted at falling edge after 8th bit, released at next falling edge.
- First read bit driven at falling edge ending DEVACK; subsequent bytes load at MACK rising edge.
- WR_STB: exactly 1 cycle, registered, one cycle after 8th-bit rising edge detect.
- BUSY rises with DEVACK entry, falls cycle after STOP or NACK detect.
- Supports SCL up to 1 MHz (≥10 CLK40 cycles per phase).
- RST mid-transfer: SDA_OE 0 on next cycle; bus transaction aborted; block waits for next START.

## Test plan
- Write 0xA2, 0x03, 0x5A, 0xC3, STOP -> ACK on all 4 bytes; regs[3]=0x5A, regs[4]=0xC3; two WR_STB pulses (addr 3, 4).
- Write pointer 0x0F, restart, 0xA3, read 3 bytes ACK,ACK,NACK -> returns regs[15], regs[0], regs[1]; SDA released after NACK.
- Address 0xA4 -> no ACK (SDA_OE stays 0 throughout), BUSY stays 0, no register change.
- Local LCL_WE addr 5 data 0x11 in same cycle as I2C commit to addr 5 data 0x22 -> regs[5]=0x22; LCL_RDATA at addr 5 reads 0x22.
- STOP injected mid-byte of WDATA -> IDLE, no WR_STB, register unchanged; following full transaction succeeds.
- RST asserted during RDATA driving low -> SDA_OE 0 next cycle, all regs read 0x00 afterwards.

Source files
------------

// File: rtl/i2c_slave_regs.sv
// I2C target with a 16 x 8-bit register file, oversampling SCL/SDA on CLK40.
// Master writes set a pointer and then fill registers; master reads stream registers MSB first.
module i2c_slave_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h51
) (
  input  logic       CLK40,
  input  logic       RST,
  input  logic       SCL_IN,
  input  logic       SDA_IN,
  output logic       SDA_OE,
  input  logic       LCL_WE,
  input  logic [3:0] LCL_ADDR,
  input  logic [7:0] LCL_WDATA,
  output logic [7:0] LCL_RDATA,
  output logic       WR_STB,
  output logic [3:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  output logic       BUSY,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_DEVADR = 4'd1,
    S_DEVACK = 4'd2,
    S_PTR    = 4'd3,
    S_PTRACK = 4'd4,
    S_WDATA  = 4'd5,
    S_WDACK  = 4'd6,
    S_RDATA  = 4'd7,
    S_MACK   = 4'd8,
    S_IGNORE = 4'd9
  } state_t;

  // Synchronizers reset to the idle-bus level so reset never fabricates an edge.
  logic scl_s1, scl_s2, scl_h;
  logic sda_s1, sda_s2, sda_h;

  always_ff @(posedge CLK40) begin
    if (RST) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_h  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_h  <= 1'b1;
    end else begin
      scl_s1 <= SCL_IN;
      scl_s2 <= scl_s1;
      scl_h  <= scl_s2;
      sda_s1 <= SDA_IN;
      sda_s2 <= sda_s1;
      sda_h  <= sda_s2;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s2 & ~scl_h;
  assign scl_fall  = ~scl_s2 & scl_h;
  assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
  assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;

  state_t     state;
  logic [7:0] shift;
  logic [3:0] bit_cnt;
  logic       ack_on;
  logic       rw;
  logic [3:0] ptr;
  logic [7:0] regs [16];

  logic [7:0] byte_next;
  logic [3:0] ptr_inc;
  assign byte_next = {shift[6:0], sda_s2};
  assign ptr_inc   = ptr + 4'd1;
  assign dbg_state = state;

  always_ff @(posedge CLK40) begin
    if (RST) begin
      state     <= S_IDLE;
      shift     <= 8'h00;
      bit_cnt   <= 4'd0;
      ack_on    <= 1'b0;
      rw        <= 1'b0;
      ptr       <= 4'd0;
      SDA_OE    <= 1'b0;
      BUSY      <= 1'b0;
      WR_STB    <= 1'b0;
      WR_ADDR   <= 4'd0;
      WR_DATA   <= 8'h00;
      LCL_RDATA <= 8'h00;
      for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
    end else begin
      WR_STB    <= 1'b0;
      LCL_RDATA <= regs[LCL_ADDR];
      // The local write is issued first so a same-address I2C commit below overrides it.
      if (LCL_WE) regs[LCL_ADDR] <= LCL_WDATA;

      if (stop_det) begin
        state   <= S_IDLE;
        SDA_OE  <= 1'b0;
        BUSY    <= 1'b0;
        ack_on  <= 1'b0;
        bit_cnt <= 4'd0;
      end else if (start_det) begin
        state   <= S_DEVADR;
        SDA_OE  <= 1'b0;
        ack_on  <= 1'b0;
        bit_cnt <= 4'd0;
      end else begin
        case (state)
          S_DEVADR: begin
            if (scl_rise) begin
              shift <= byte_next;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                rw      <= sda_s2;
                if (shift[6:0] == DEV_ADDR) begin
                  state <= S_DEVACK;
                  BUSY  <= 1'b1;
                end else begin
                  state <= S_IGNORE;
                  BUSY  <= 1'b0;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          // ACK slot: first falling edge grabs SDA, second one ends the slot.
          S_DEVACK, S_PTRACK, S_WDACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                ack_on <= 1'b1;
                SDA_OE <= 1'b1;
              end else begin
                ack_on <= 1'b0;
                if (state == S_DEVACK && rw) begin
                  shift  <= regs[ptr];
                  SDA_OE <= ~regs[ptr][7];
                  state  <= S_RDATA;
                end else begin
                  SDA_OE <= 1'b0;
                  state  <= (state == S_DEVACK) ? S_PTR : S_WDATA;
                end
              end
            end
          end

          S_PTR: begin
            if (scl_rise) begin
              shift <= byte_next;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                ptr     <= byte_next[3:0];
                state   <= S_PTRACK;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          S_WDATA: begin
            if (scl_rise) begin
              shift <= byte_next;
              if (bit_cnt == 4'd7) begin
                bit_cnt   <= 4'd0;
                regs[ptr] <= byte_next;
                WR_STB    <= 1'b1;
                WR_ADDR   <= ptr;
                WR_DATA   <= byte_next;
                ptr       <= ptr_inc;
                state     <= S_WDACK;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          // bit_cnt counts rising edges of the byte; falling edges move the driven bit.
          S_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                SDA_OE  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= S_MACK;
              end else if (bit_cnt == 4'd0) begin
                SDA_OE <= ~shift[7];
              end else begin
                shift  <= {shift[6:0], 1'b0};
                SDA_OE <= ~shift[6];
              end
            end
          end

          S_MACK: begin
            if (scl_rise) begin
              if (!sda_s2) begin
                ptr   <= ptr_inc;
                shift <= regs[ptr_inc];
                state <= S_RDATA;
              end else begin
                state <= S_IGNORE;
                BUSY  <= 1'b0;
              end
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule
